// File: rtl/aux_frame_pkg.sv
// Shared constants and helpers for the aux frame packer: CRC-16/CCITT step
// and the slot-count ceil-div.
package aux_frame_pkg;

   localparam logic [15:0] CRC16_POLY       = 16'h1021;
   localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
   localparam logic [95:0] SYNC_PATTERN_DEF = 96'hDEADBEEFCAFEDEADBEEFCAFE;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Shifts the low 'width' bits of sym into crc, MSB first.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [31:0] sym,
                                              input int width);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (i < width) begin
            fb = c[15] ^ sym[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/aux_crc16.sv
// CRC-16 accumulator over AUX_W-bit symbols; init wins over enable.
module aux_crc16
   import aux_frame_pkg::*;
#(
   parameter int AUX_W = 6
) (
   input  logic             clock,
   input  logic             nReset,
   input  logic             init_i,
   input  logic             en_i,
   input  logic [AUX_W-1:0] sym_i,
   output logic [15:0]      crc_o
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init_i)    crc_d = CRC16_INIT;
      else if (en_i) crc_d = crc16_step(crc_q, 32'(sym_i), AUX_W);
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) crc_q <= CRC16_INIT;
      else         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/aux_frame_packer.sv
// Packs one ADC/test-ramp sample plus one aux frame symbol per output word;
// aux frames carry sync, channel status, an audio snapshot, CRC and sequence.
module aux_frame_packer
   import aux_frame_pkg::*;
#(
   parameter int ADC_W      = 10,
   parameter int AUX_W      = 6,
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 24,
   parameter int FRAME_LEN  = 512,
   parameter int SYNC_SLOTS = 16,
   parameter logic [SYNC_SLOTS*AUX_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
   parameter int SEQ_W      = 22,
   parameter int SEQ_LAST   = (63 << 16) - 1,
   parameter int TEST_LAST  = 1020
) (
   input  logic                     clock,
   input  logic                     nReset,
   input  logic [ADC_W-1:0]         adc_databus,
   input  logic                     testModeFlag,
   input  logic [NUM_CH*CH_W-1:0]   ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [ADC_W+AUX_W-1:0]   dataOut,
   output logic                     frame_start,
   output logic                     overrun
);

   localparam int CH_SLOTS  = ceil_div(CH_W, AUX_W);
   localparam int CRC_SLOTS = ceil_div(16, AUX_W);
   localparam int ST_SLOT   = SYNC_SLOTS;
   localparam int CRC_FIRST = ST_SLOT + 1 + NUM_CH * CH_SLOTS;
   localparam int SEQ_FIRST = CRC_FIRST + CRC_SLOTS;
   localparam int SLOT_W    = $clog2(FRAME_LEN);
   localparam int CHP_W     = CH_SLOTS * AUX_W;
   localparam int CRCP_W    = CRC_SLOTS * AUX_W;

   logic [SLOT_W-1:0]             slot_q, slot_d;
   logic [SEQ_W-1:0]              seq_q, seq_d;
   logic [ADC_W-1:0]              ramp_q, ramp_d;
   logic [NUM_CH-1:0][CH_W-1:0]   latch_q, snap_q;
   logic [NUM_CH-1:0]             flag_q, flag_d;
   logic                          ovf_q, ovf_d, overrun_q, overrun_d;
   logic [AUX_W-1:0]              status_q, status_d;
   logic [ADC_W+AUX_W-1:0]        dout_q;
   logic                          fstart_q;
   logic [AUX_W-1:0]              aux;
   logic [CHP_W-1:0]              chp;
   logic [CRCP_W-1:0]             crcp;
   logic [15:0]                   crc;
   logic                          snapshot, dbl;
   int                            slot_i, j, m;

   assign slot_i   = int'(slot_q);
   assign snapshot = (slot_i == SYNC_SLOTS - 1);

   always_comb begin
      slot_d = (slot_i == FRAME_LEN - 1) ? '0 : slot_q + SLOT_W'(1);
      seq_d  = (seq_q == SEQ_W'(SEQ_LAST)) ? '0 : seq_q + SEQ_W'(1);
      ramp_d = (ramp_q == ADC_W'(TEST_LAST)) ? '0 : ramp_q + ADC_W'(1);
      // A strobe on the snapshot cycle opens the next interval, so it never counts as a repeat.
      dbl       = (|(flag_q & ch_valid)) & ~snapshot;
      flag_d    = snapshot ? ch_valid : (flag_q | ch_valid);
      ovf_d     = snapshot ? 1'b0 : (ovf_q | dbl);
      overrun_d = overrun_q | dbl;
      status_d  = status_q;
      if (snapshot) begin
         status_d               = '0;
         status_d[NUM_CH-1:0]   = flag_q;
         status_d[AUX_W-1]      = ovf_q;
      end
   end

   always_comb begin
      aux  = seq_q[SEQ_W-1 -: AUX_W];
      chp  = '0;
      crcp = CRCP_W'(crc);
      j    = slot_i - ST_SLOT - 1;
      m    = 0;
      if (slot_i < ST_SLOT) begin
         aux = AUX_W'(SYNC_PATTERN >> (slot_i * AUX_W));
      end else if (slot_i == ST_SLOT) begin
         aux = status_q;
      end else if (slot_i < CRC_FIRST) begin
         m = j % CH_SLOTS;
         for (int c = 0; c < NUM_CH; c++)
            if (c == j / CH_SLOTS) chp = CHP_W'(snap_q[c]);
         aux = AUX_W'(chp >> ((CH_SLOTS - 1 - m) * AUX_W));
      end else if (slot_i < SEQ_FIRST) begin
         m   = slot_i - CRC_FIRST;
         aux = AUX_W'(crcp >> ((CRC_SLOTS - 1 - m) * AUX_W));
      end
   end

   aux_crc16 #(.AUX_W(AUX_W)) u_crc (
      .clock  (clock),
      .nReset (nReset),
      .init_i (slot_i == 0),
      .en_i   (slot_i >= ST_SLOT && slot_i < CRC_FIRST),
      .sym_i  (aux),
      .crc_o  (crc)
   );

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         slot_q    <= '0;
         seq_q     <= '0;
         ramp_q    <= '0;
         latch_q   <= '0;
         snap_q    <= '0;
         flag_q    <= '0;
         ovf_q     <= 1'b0;
         overrun_q <= 1'b0;
         status_q  <= '0;
         dout_q    <= '0;
         fstart_q  <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         seq_q     <= seq_d;
         ramp_q    <= ramp_d;
         flag_q    <= flag_d;
         ovf_q     <= ovf_d;
         overrun_q <= overrun_d;
         status_q  <= status_d;
         for (int c = 0; c < NUM_CH; c++)
            if (ch_valid[c]) latch_q[c] <= ch_data[c*CH_W +: CH_W];
         if (snapshot) snap_q <= latch_q;
         dout_q    <= {aux, testModeFlag ? ramp_q : adc_databus};
         fstart_q  <= (slot_i == 0);
      end
   end

   assign dataOut     = dout_q;
   assign frame_start = fstart_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_aux_frame_packer.sv
// Bench for aux_frame_packer: random stimulus against an event-log frame model.
module tb_aux_frame_packer;
   import aux_frame_pkg::*;

   localparam int FL = 512, SS = 16, TL = 1020, SQW = 10, SQL = 1007;
   localparam logic [95:0] SYNC = 96'hDEADBEEFCAFEDEADBEEFCAFE;

   logic        clock = 1'b0, nReset = 1'b0, testModeFlag = 1'b0;
   logic [9:0]  adc_databus = '0;
   logic [95:0] ch_data = '0;
   logic [3:0]  ch_valid = '0;
   logic [15:0] dataOut;
   logic        frame_start, overrun;

   int n_chk = 0, n_fail = 0, n_edge = 0;
   int ev_e[$], ev_c[$];
   logic [23:0] ev_d[$];
   logic [9:0]  low_q[$];

   aux_frame_packer #(.SEQ_W(SQW), .SEQ_LAST(SQL)) dut (
      .clock(clock), .nReset(nReset), .adc_databus(adc_databus), .testModeFlag(testModeFlag),
      .ch_data(ch_data), .ch_valid(ch_valid), .dataOut(dataOut), .frame_start(frame_start),
      .overrun(overrun));

   always #5 clock = ~clock;

   // Strobe interval index: interval f feeds the status/snapshot of frame f.
   function automatic int ival(input int e);
      return (e < SS) ? 0 : (e - SS) / FL + 1;
   endfunction

   function automatic logic [5:0] exp_aux(input int n);
      int k, f, cnt[4];
      logic [5:0] sy[17];
      logic [15:0] crc;
      logic [23:0] snap;
      logic ov;
      k = (n - 1) % FL; f = (n - 1) / FL; ov = 1'b0;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      foreach (ev_e[i]) if (ival(ev_e[i]) == f) cnt[ev_c[i]]++;
      sy[0] = '0;
      for (int c = 0; c < 4; c++) begin
         sy[0][c] = (cnt[c] > 0);
         if (cnt[c] > 1) ov = 1'b1;
      end
      sy[0][5] = ov;
      for (int c = 0; c < 4; c++) begin
         snap = '0;
         foreach (ev_e[i]) if (ev_c[i] == c && ev_e[i] < f * FL + SS) snap = ev_d[i];
         for (int q = 0; q < 4; q++) sy[1 + c * 4 + q] = 6'(snap >> ((3 - q) * 6));
      end
      crc = 16'hFFFF;
      for (int i = 0; i < 17; i++) crc = crc16_step(crc, 32'(sy[i]), 6);
      if (k < SS) return 6'(SYNC >> (k * 6));
      if (k <= SS + 16) return sy[k - SS];
      if (k < SS + 20) return 6'({2'b00, crc} >> ((SS + 19 - k) * 6));
      return 6'(((n - 1) % (SQL + 1)) >> (SQW - 6));
   endfunction

   function automatic logic [15:0] exp_word(input int n);
      return {exp_aux(n), low_q[n - 1]};
   endfunction

   function automatic logic exp_ovr(input int n);
      foreach (ev_e[i])
         for (int k = i + 1; k < ev_e.size(); k++)
            if (ev_c[k] == ev_c[i] && ival(ev_e[k]) == ival(ev_e[i]) && ev_e[k] <= n) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] rv(input int p);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = ($urandom_range(0, p - 1) == 0);
      return r;
   endfunction

   function automatic logic [95:0] rd();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic step(input logic tm, input logic [3:0] v, input logic [95:0] d);
      logic [9:0] adc;
      adc = 10'($urandom);
      testModeFlag = tm; adc_databus = adc; ch_valid = v; ch_data = d;
      @(posedge clock);
      n_edge++;
      low_q.push_back(tm ? 10'((n_edge - 1) % (TL + 1)) : adc);
      for (int c = 0; c < 4; c++)
         if (v[c]) begin ev_e.push_back(n_edge); ev_c.push_back(c); ev_d.push_back(d[c*24 +: 24]); end
      #1;
   endtask

   task automatic clear_model();
      ev_e.delete(); ev_c.delete(); ev_d.delete(); low_q.delete(); n_edge = 0;
   endtask

   task automatic do_reset();
      nReset = 1'b0; ch_valid = '0; testModeFlag = 1'b0;
      @(posedge clock); #1;
      nReset = 1'b1;
      clear_model();
   endtask

   task automatic test_reset();
      logic [7:0] msg[9];
      logic [15:0] c;
      nReset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_chk++; if (dataOut !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0000", dataOut); end
      n_chk++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", frame_start); end
      n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", overrun); end
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      c = 16'hFFFF;
      for (int i = 0; i < 9; i++) c = crc16_step(c, 32'(msg[i]), 8);
      n_chk++; if (c !== 16'h29B1) begin n_fail++; $display("FAIL crc_vector got %h exp 29b1", c); end
      nReset = 1'b1;
      clear_model();
      step(1'b1, 4'b0, rd());
      n_chk++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL first_fs got %b exp 1", frame_start); end
      n_chk++; if (dataOut !== {6'h3E, 10'd0}) begin n_fail++; $display("FAIL first_word got %h exp %h", dataOut, {6'h3E, 10'd0}); end
   endtask

   task automatic test_ramp_frame();
      do_reset();
      for (int i = 0; i < 1100; i++) begin
         step(1'b1, 4'b0, rd());
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL ramp_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         n_chk++; if (frame_start !== ((n_edge - 1) % FL == 0)) begin n_fail++; $display("FAIL ramp_fs n=%0d got %b", n_edge, frame_start); end
         if (n_edge == 1021 || n_edge == 1022) begin
            n_chk++;
            if (dataOut[9:0] !== ((n_edge == 1021) ? 10'd1020 : 10'd0)) begin n_fail++; $display("FAIL ramp_wrap n=%0d got %0d", n_edge, dataOut[9:0]); end
         end
      end
   endtask

   task automatic test_seq_wrap();
      do_reset();
      for (int i = 0; i < 1010; i++) begin
         step(1'($urandom), 4'b0, rd());
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL seq_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         if (n_edge == 1008 || n_edge == 1009) begin
            n_chk++;
            if (dataOut[15:10] !== ((n_edge == 1008) ? 6'd62 : 6'd0)) begin n_fail++; $display("FAIL seq_wrap n=%0d got %0d", n_edge, dataOut[15:10]); end
         end
      end
   endtask

   task automatic test_snapshot();
      logic [5:0] p0[4], p2[4];
      logic [95:0] d;
      logic [3:0] v;
      p0 = '{6'h04, 6'h23, 6'h11, 6'h16};
      p2 = '{6'h2A, 6'h3C, 6'h37, 6'h2F};
      do_reset();
      for (int i = 0; i < 560; i++) begin
         d = rd(); v = 4'b0;
         if (n_edge + 1 == 5) begin v = 4'b0101; d[23:0] = 24'h123456; d[71:48] = 24'hABCDEF; end
         step(1'b0, v, d);
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL snap_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL snap_ovr n=%0d got %b exp 0", n_edge, overrun); end
         if (n_edge == 17) begin
            n_chk++; if (dataOut[15:10] !== 6'b000101) begin n_fail++; $display("FAIL snap_status got %b exp 000101", dataOut[15:10]); end
         end
         if (n_edge >= 18 && n_edge <= 21) begin
            n_chk++; if (dataOut[15:10] !== p0[n_edge - 18]) begin n_fail++; $display("FAIL snap_ch0 n=%0d got %h exp %h", n_edge, dataOut[15:10], p0[n_edge - 18]); end
         end
         if (n_edge >= 26 && n_edge <= 29) begin
            n_chk++; if (dataOut[15:10] !== p2[n_edge - 26]) begin n_fail++; $display("FAIL snap_ch2 n=%0d got %h exp %h", n_edge, dataOut[15:10], p2[n_edge - 26]); end
         end
      end
   endtask

   task automatic test_snapshot_edge();
      logic [95:0] d;
      logic [3:0] v;
      do_reset();
      for (int i = 0; i < 1100; i++) begin
         d = rd(); v = 4'b0;
         if (n_edge + 1 == 3)   begin v = 4'b0010; d[47:24] = 24'h3C5A96; end
         if (n_edge + 1 == 528) begin v = 4'b0010; d[47:24] = 24'hC3A569; end
         step(1'($urandom), v, d);
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL edge_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         if (n_edge == 529 || n_edge == 1041) begin
            n_chk++;
            if (dataOut[11] !== (n_edge == 1041)) begin n_fail++; $display("FAIL edge_status_b1 n=%0d got %b", n_edge, dataOut[11]); end
         end
         if (n_edge == 534 || n_edge == 1046) begin
            n_chk++;
            if (dataOut[15:10] !== ((n_edge == 534) ? 6'h0F : 6'h30)) begin n_fail++; $display("FAIL edge_ch1 n=%0d got %h", n_edge, dataOut[15:10]); end
         end
      end
   endtask

   task automatic test_overrun();
      logic [3:0] v;
      do_reset();
      for (int i = 0; i < 1100; i++) begin
         v = (n_edge + 1 == 4 || n_edge + 1 == 9) ? 4'b1000 : 4'b0;
         step(1'b0, v, rd());
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL ovr_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         n_chk++; if (overrun !== (n_edge >= 9)) begin n_fail++; $display("FAIL ovr_sticky n=%0d got %b exp %b", n_edge, overrun, n_edge >= 9); end
         if (n_edge == 17 || n_edge == 529) begin
            n_chk++;
            if (dataOut[15:10] !== ((n_edge == 17) ? 6'b101000 : 6'b000000)) begin n_fail++; $display("FAIL ovr_status n=%0d got %b", n_edge, dataOut[15:10]); end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 301; i++) begin
         step(1'($urandom), rv(6), rd());
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL pre_rst_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         n_chk++; if (overrun !== exp_ovr(n_edge)) begin n_fail++; $display("FAIL pre_rst_ovr n=%0d got %b", n_edge, overrun); end
      end
      #2 nReset = 1'b0;
      #1;
      n_chk++; if (dataOut !== 16'h0) begin n_fail++; $display("FAIL mid_rst_dout got %h exp 0000", dataOut); end
      n_chk++; if (frame_start !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags got fs=%b ovr=%b exp 0 0", frame_start, overrun); end
      @(posedge clock); #1;
      nReset = 1'b1;
      clear_model();
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom), rv(40), rd());
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL post_rst_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         if (n_edge == 1) begin
            n_chk++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL post_rst_fs got %b exp 1", frame_start); end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1600; i++) begin
         step(1'($urandom), rv(30), rd());
         n_chk++; if (dataOut !== exp_word(n_edge)) begin n_fail++; $display("FAIL rnd_word n=%0d got %h exp %h", n_edge, dataOut, exp_word(n_edge)); end
         n_chk++; if (frame_start !== ((n_edge - 1) % FL == 0)) begin n_fail++; $display("FAIL rnd_fs n=%0d got %b", n_edge, frame_start); end
         n_chk++; if (overrun !== exp_ovr(n_edge)) begin n_fail++; $display("FAIL rnd_ovr n=%0d got %b exp %b", n_edge, overrun, exp_ovr(n_edge)); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_frame();
      test_seq_wrap();
      test_snapshot();
      test_snapshot_edge();
      test_overrun();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aux_frame_packer.md
# aux_frame_packer

Parametrised successor to the RF sample word generator. Each output word carries one ADC sample (or test ramp value) in its low bits and one aux symbol in its top bits. Aux symbols form fixed-length frames containing:
- a sync pattern,
- a channel-status symbol,
- a frame-consistent snapshot of N audio channels,
- a computed CRC-16,
- the sequence number.

Sits between the ADC and audio capture front-ends and the USB/FIFO output path.

## Interface
- ADC_W, 10, ADC sample width (low field of dataOut)
- AUX_W, 6, aux symbol width (top field of dataOut)
- NUM_CH, 4, audio channel count; requires NUM_CH <= AUX_W-1
- CH_W, 24, audio channel sample width
- FRAME_LEN, 512, words per frame; requires SYNC_SLOTS+1+NUM_CH*CH_SLOTS+CRC_SLOTS <= FRAME_LEN
- SYNC_SLOTS, 16, sync symbol count
- SYNC_PATTERN, 96'hDEADBEEFCAFEDEADBEEFCAFE, width SYNC_SLOTS*AUX_W, emitted LSB-symbol first
- SEQ_W, 22, sequence counter width
- SEQ_LAST, (63<<16)-1, sequence counter wrap value
- TEST_LAST, 1020, test ramp wrap value
- Derived constants:
  - CH_SLOTS = ceil(CH_W/AUX_W)
  - CRC_SLOTS = ceil(16/AUX_W)
- Reset and clock: reset nReset, asynchronous, active-low; clock clock.
- clock  in  1  sample clock, all logic on rising edge
- nReset  in  1  asynchronous active-low reset
- adc_databus  in  ADC_W  raw ADC sample
- testModeFlag  in  1  1 = low field carries test ramp instead of ADC
- ch_data  in  NUM_CH*CH_W  channel samples, channel i at [i*CH_W +: CH_W]
- ch_valid  in  NUM_CH  per-channel one-cycle strobe, ch_data slice valid
- dataOut  out  ADC_W+AUX_W  {aux symbol, sample}
- frame_start  out  1  high on the cycle dataOut carries slot 0
- overrun  out  1  sticky; set when any channel strobes twice between snapshots; cleared only by reset

## Operation
- Slot counter runs 0..FRAME_LEN-1 and wraps to 0.
- Frame layout by slot k:
  - 0..SYNC_SLOTS-1: SYNC_PATTERN[k*AUX_W +: AUX_W].
  - S = SYNC_SLOTS: status symbol. Bit i = channel i strobed since the previous snapshot. Bit AUX_W-1 = overrun occurred in that interval. Other bits are 0.
  - S+1 .. S+NUM_CH*CH_SLOTS: snapshot channels. Channel 0 first, each channel MSB-first. Each sample is left-padded with zeros to CH_SLOTS*AUX_W.
  - Next CRC_SLOTS slots: CRC-16, zero-left-padded to CRC_SLOTS*AUX_W, MSB-first.
  - Remaining slots: sequenceCount[SEQ_W-1 -: AUX_W].
- Latching:
  - Each ch_valid strobe loads the working latch and sets that channel's new flag.
  - A second strobe before the next snapshot sets the per-frame overrun flag and the sticky overrun output.
- Snapshot: on the cycle the slot counter equals SYNC_SLOTS-1, three things happen together:
  - working latches copy into the snapshot buffer;
  - flags copy into the status register;
  - flags clear.
- Strobe on the snapshot cycle:
  - the snapshot takes the pre-strobe latch value;
  - the strobe sets its flag for the next frame (it is not lost).
- CRC definition:
  - CRC-16/CCITT, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Input is the status symbol and all payload symbols, each processed MSB-first, one symbol per cycle.
  - The CRC reinitialises at slot 0.
- Sequence counter:
  - increments every cycle, independent of frame position;
  - SEQ_LAST -> 0.
- Test ramp: 0..TEST_LAST, then 0.
- testModeFlag is sampled every cycle; switching it mid-frame affects only the low field.

## Timing
- Reset values:
  - dataOut, slot counter, sequenceCount, test ramp, latches, snapshot, flags, overrun: all 0.
  - frame_start: 0.
  - CRC register: 0xFFFF.
- First clock after reset release: dataOut carries slot-0 sync symbol and adc_databus of the previous edge; frame_start=1.
- Latency: adc_databus to dataOut low field is 1 cycle. The aux symbol for slot k is registered on the same edge, so the pair is word-aligned.
- Latch to output:
  - A strobe at cycle t is visible in the snapshot of the next frame whose snapshot edge is >= t+1.
  - The snapshot appears at slot S+1, 2 cycles after the snapshot edge.
- The CRC value emitted equals the CRC over exactly the symbols output in the same frame.
- Reset asserted mid-frame: everything returns to reset values immediately; the next frame starts at slot 0.

## Structure
- Shared package aux_frame_pkg holds:
  - CRC16_POLY, CRC16_INIT;
  - the default SYNC_PATTERN;
  - ceil-div function for CH_SLOTS/CRC_SLOTS;
  - the function crc16_step(crc, symbol, width), also used by the bench model.
- One sub-module, aux_crc16: CRC register with init/enable inputs and a symbol input, parametrised on AUX_W.

## Test plan
- Reset release, testModeFlag=1, no strobes -> dataOut low field 0,1,2..1020,0. Slots 0..15 are 0xDEADBEEFCAFEDEADBEEFCAFE symbols LSB-first. Status=0, payload all 0, CRC matches the model.
- ch_valid=4'b0101 with ch0=24'h123456, ch2=24'hABCDEF, before slot 15 -> status 6'b000101. Payload ch0 = 04,23,11,16 (6-bit). ch2 = 2A,3C,37,2F. CRC matches the model.
- Strobe ch1 exactly on the slot-15 cycle -> current frame status bit1=0 with the old ch1 value. Next frame bit1=1 with the new value.
- Two ch3 strobes in one frame -> status bit5=1. overrun output goes high and stays high through later clean frames.
- sequenceCount driven past SEQ_LAST -> wraps to 0. Top field on sequence slots shows 62 then 0.
- nReset pulse at slot 300 -> dataOut 0, frame_start on the first post-reset cycle. CRC restarts from 0xFFFF.
